// File: rtl/bitty_pkg.sv
// Shared types and constants for the Bitty core family.
// Instruction field positions follow from REG_AW, so they are derived in the core.
package bitty_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_CMP = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FMT_REG = 2'd0,
    FMT_IMM = 2'd1
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  // ops 8..15 and formats 2/3 are reserved
  function automatic logic is_legal(input logic [3:0] op, input logic [1:0] fmt);
    return !op[3] && !fmt[1];
  endfunction

endpackage

// File: rtl/bitty_alu.sv
// Combinational Bitty ALU: arithmetic wraps mod 2^DATA_W, carry_out is ADD carry or SUB borrow.
module bitty_alu
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] out,
  output logic              carry_out
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [SH_W-1:0] shamt;

  assign sum   = {1'b0, in_a} + {1'b0, in_b};
  // top bit of the extended difference is set exactly when in_a < in_b
  assign diff  = {1'b0, in_a} - {1'b0, in_b};
  assign shamt = in_b[SH_W-1:0];

  always_comb begin
    out       = '0;
    carry_out = 1'b0;
    case (op)
      OP_ADD: begin
        out       = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      OP_SUB: begin
        out       = diff[DATA_W-1:0];
        carry_out = diff[DATA_W];
      end
      OP_AND: out = in_a & in_b;
      OP_OR:  out = in_a | in_b;
      OP_XOR: out = in_a ^ in_b;
      OP_SHL: out = in_a << shamt;
      OP_SHR: out = in_a >> shamt;
      OP_CMP: begin
        if (in_a == in_b)     out = DATA_W'(CMP_EQ);
        else if (in_a > in_b) out = DATA_W'(CMP_GT);
        else                  out = DATA_W'(CMP_LT);
      end
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/bitty_core.sv
// Bitty datapath: register file, S/C/instruction registers and a 4-state sequencer.
//   state  | meaning
//   IDLE   | waiting for an instruction, instr_ready high
//   LOAD_S | S <= R[rx]
//   EXEC   | C <= alu(S, R[ry] or imm)
//   WB     | R[rx]/result/carry written, done pulses next cycle; may accept the next instruction
module bitty_core
  import bitty_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int REG_AW   = $clog2(NUM_REGS),
  localparam int INSTR_W  = 2*REG_AW + 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               carry,
  output logic               illegal,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int IMM_W = INSTR_W - REG_AW - 6;

  state_e              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   s_reg;
  logic [DATA_W-1:0]   c_reg;
  logic                c_carry;

  logic [REG_AW-1:0]   rx;
  logic [REG_AW-1:0]   ry;
  logic [3:0]          op;
  logic [1:0]          fmt;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   operand_b;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_carry;

  assign rx  = ir[INSTR_W-1 -: REG_AW];
  assign ry  = ir[INSTR_W-REG_AW-1 -: REG_AW];
  // the immediate overlaps the ry field; fmt decides which reading applies
  assign imm = ir[INSTR_W-REG_AW-1:6];
  assign op  = ir[5:2];
  assign fmt = ir[1:0];

  assign operand_b = (fmt == FMT_IMM) ? DATA_W'(imm) : regs[ry];

  // WB shares the accept edge with writeback, giving one instruction every 3 cycles
  assign instr_ready = (state == IDLE) || (state == WB);
  assign dbg_data    = regs[dbg_addr];

  bitty_alu #(.DATA_W(DATA_W)) u_alu (
    .in_a      (s_reg),
    .in_b      (operand_b),
    .op        (op),
    .out       (alu_out),
    .carry_out (alu_carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ir      <= '0;
      s_reg   <= '0;
      c_reg   <= '0;
      c_carry <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= LOAD_S;
          end
        end
        LOAD_S: begin
          s_reg <= regs[rx];
          state <= EXEC;
        end
        EXEC: begin
          c_reg   <= alu_out;
          c_carry <= alu_carry;
          state   <= WB;
        end
        WB: begin
          done <= 1'b1;
          if (is_legal(op, fmt)) begin
            regs[rx] <= c_reg;
            result   <= c_reg;
            if (op == OP_ADD || op == OP_SUB) carry <= c_carry;
          end else begin
            illegal <= 1'b1;
          end
          if (instr_valid) begin
            ir    <= instr;
            state <= LOAD_S;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_core.sv
// Self-checking bench for bitty_core: directed vector table, multi-cycle sequences,
// and random instructions checked against an arithmetic reference model.
module tb_bitty_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int tests = 0;
  int fails = 0;

  int unsigned m_regs [8];
  logic [15:0] m_res;
  logic        m_cy;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] exp_res;
    logic        exp_cy;
    logic        exp_ill;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs [20];

  bitty_core dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .done        (done),
    .result      (result),
    .carry       (carry),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int rx, input int ry, input int op);
    return {rx[2:0], ry[2:0], 4'b0000, op[3:0], 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(input int rx, input int imm, input int op);
    return {rx[2:0], imm[6:0], op[3:0], 2'b01};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_res = '0;
    m_cy  = 1'b0;
  endtask

  // Spec-level semantics in plain unsigned arithmetic; returns the predicted illegal flag.
  task automatic model_exec(input logic [15:0] ins, output logic ill);
    int unsigned s, b, r, rx, ry, op, fmt;
    rx  = ins[15:13];
    ry  = ins[12:10];
    op  = ins[5:2];
    fmt = ins[1:0];
    ill = !(op < 8 && fmt < 2);
    if (ill) return;
    s = m_regs[rx];
    b = (fmt == 1) ? ins[12:6] : m_regs[ry];
    r = 0;
    case (op)
      0: begin r = s + b; m_cy = (r > 65535); end
      1: begin r = s - b; m_cy = (s < b); end
      2: r = s & b;
      3: r = s | b;
      4: r = s ^ b;
      5: r = s << (b % 16);
      6: r = s >> (b % 16);
      default: r = (s == b) ? 0 : ((s > b) ? 1 : 2);
    endcase
    r = r % 65536;
    m_regs[rx] = r;
    m_res = r[15:0];
  endtask

  // Issues one instruction and checks the full 3-cycle timeline; returns at
  // negedge+1 of the done cycle so callers can still see done/illegal.
  task automatic run_instr(input logic [15:0] ins);
    int   n = 0;
    logic ill;
    while (!instr_ready && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_before_accept", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    model_exec(ins, ill);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk("done_early", done, 1'b0);
      chk("ready_busy", instr_ready, (k == 3));
    end
    @(negedge clk);
    dbg_addr = ins[15:13];
    #1;
    chk("done_pulse", done, 1'b1);
    chk("illegal_flag", illegal, ill);
    chk("result", result, m_res);
    chk("carry", carry, m_cy);
    chk("reg_rx", dbg_data, m_regs[ins[15:13]]);
  endtask

  task automatic sweep_regs(input string nm);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(nm, dbg_data, m_regs[i]);
    end
  endtask

  initial begin
    logic [15:0] b2b_ins [3];
    logic [15:0] b2b_res [3];
    logic        ill;

    vecs[0]  = '{enc_i(1, 5, 0),  16'd5,     1'b0, 1'b0, 16'd5};
    vecs[1]  = '{enc_i(2, 7, 0),  16'd7,     1'b0, 1'b0, 16'd7};
    vecs[2]  = '{enc_r(1, 2, 0),  16'd12,    1'b0, 1'b0, 16'd12};
    vecs[3]  = '{enc_i(4, 1, 0),  16'd1,     1'b0, 1'b0, 16'd1};
    vecs[4]  = '{enc_r(3, 4, 1),  16'hFFFF,  1'b1, 1'b0, 16'hFFFF};
    vecs[5]  = '{enc_i(3, 1, 0),  16'd0,     1'b1, 1'b0, 16'd0};
    vecs[6]  = '{enc_i(5, 9, 0),  16'd9,     1'b0, 1'b0, 16'd9};
    vecs[7]  = '{enc_i(6, 4, 0),  16'd4,     1'b0, 1'b0, 16'd4};
    vecs[8]  = '{enc_r(5, 6, 7),  16'd1,     1'b0, 1'b0, 16'd1};
    vecs[9]  = '{enc_r(6, 2, 7),  16'd2,     1'b0, 1'b0, 16'd2};
    vecs[10] = '{enc_i(7, 7, 0),  16'd7,     1'b0, 1'b0, 16'd7};
    vecs[11] = '{enc_r(7, 2, 7),  16'd0,     1'b0, 1'b0, 16'd0};
    vecs[12] = '{enc_r(2, 2, 0),  16'd14,    1'b0, 1'b0, 16'd14};
    vecs[13] = '{enc_r(1, 2, 10), 16'd14,    1'b0, 1'b1, 16'd12};
    vecs[14] = '{16'b001_010_0000_0000_10, 16'd14, 1'b0, 1'b1, 16'd12};
    vecs[15] = '{enc_i(1, 4, 5),  16'd192,   1'b0, 1'b0, 16'd192};
    vecs[16] = '{enc_i(1, 3, 6),  16'd24,    1'b0, 1'b0, 16'd24};
    vecs[17] = '{enc_r(1, 2, 4),  16'd22,    1'b0, 1'b0, 16'd22};
    vecs[18] = '{enc_i(1, 18, 2), 16'd18,    1'b0, 1'b0, 16'd18};
    vecs[19] = '{enc_i(1, 65, 3), 16'd83,    1'b0, 1'b0, 16'd83};

    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_result", result, 16'd0);
    chk("rst_carry", carry, 1'b0);
    sweep_regs("rst_regs");
    @(negedge clk);
    reset = 1'b1;
    #1;

    // directed table
    for (int i = 0; i < 20; i++) begin
      run_instr(vecs[i].ins);
      dbg_addr = vecs[i].ins[15:13];
      #1;
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_carry", i), carry, vecs[i].exp_cy);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].exp_ill);
      chk($sformatf("vec%0d_reg", i), dbg_data, vecs[i].exp_reg);
    end
    sweep_regs("table_regs");

    // back-to-back: valid held high across three instructions
    b2b_ins[0] = enc_i(1, 3, 0);
    b2b_ins[1] = enc_r(1, 1, 0);
    b2b_ins[2] = enc_r(2, 1, 1);
    for (int j = 0; j < 3; j++) begin
      model_exec(b2b_ins[j], ill);
      b2b_res[j] = m_res;
    end
    @(negedge clk); #1;
    instr_valid = 1'b1;
    instr       = b2b_ins[0];
    @(posedge clk); #1;
    instr = b2b_ins[1];
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 3) instr = b2b_ins[2];
      if (k == 6) instr_valid = 1'b0;
      @(negedge clk); #1;
      chk($sformatf("b2b_done_k%0d", k), done, (k % 3 == 0));
      chk($sformatf("b2b_ready_k%0d", k), instr_ready, (k % 3 == 2) || (k == 9));
      if (k % 3 == 0) chk($sformatf("b2b_result_k%0d", k), result, b2b_res[k/3 - 1]);
    end
    sweep_regs("b2b_regs");

    // reset asserted while the instruction is in EXEC
    @(negedge clk); #1;
    instr_valid = 1'b1;
    instr       = enc_i(4, 100, 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("abort_ready", instr_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    sweep_regs("abort_regs");
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_done_hold", done, 1'b0);
    end
    chk("abort_result", result, 16'd0);
    chk("abort_carry", carry, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    run_instr(enc_i(1, 5, 0));
    chk("rerun_result", result, 16'd5);

    // randomized instructions
    for (int t = 0; t < 60; t++) begin
      logic [3:0]  op;
      logic [1:0]  fmt;
      logic [15:0] ins;
      op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      fmt = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      ins = {3'($urandom), 7'($urandom), op, fmt};
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
      run_instr(ins);
    end
    sweep_regs("final_regs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
